// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data memory, one transaction in flight.
// Priority goes to DM; a starvation counter hands IF the port after STARVE_MAX DM grants.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic       OWN_IF  = 1'b0;
   localparam logic       OWN_DM  = 1'b1;
   localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

   state_t     state, state_nxt;
   logic       owner, owner_nxt;
   logic [3:0] starve_cnt, starve_nxt;
   logic       kill_pend, kill_nxt;
   logic       if_ok, grant, grant_if;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN_IF;
         starve_cnt <= '0;
         kill_pend  <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         starve_cnt <= starve_nxt;
         kill_pend  <= kill_nxt;
      end
   end

   always_comb begin
      if_ok      = if_req & ~if_kill;
      grant_if   = if_ok & (~dm_req | (starve_cnt == CNT_MAX));
      grant      = 1'b0;
      state_nxt  = state;
      owner_nxt  = owner;
      starve_nxt = starve_cnt;
      kill_nxt   = kill_pend;
      case (state)
         IDLE: begin
            if (!if_req) starve_nxt = '0;
            if (if_ok || dm_req) begin
               grant     = 1'b1;
               state_nxt = ISSUE;
               owner_nxt = grant_if ? OWN_IF : OWN_DM;
               if (grant_if)
                  starve_nxt = '0;
               else if (if_req && starve_cnt != CNT_MAX)
                  starve_nxt = starve_cnt + 4'd1;
            end
         end
         ISSUE: begin
            if (owner == OWN_IF && if_kill) kill_nxt = 1'b1;
            if (mem_gnt) state_nxt = WAIT;
         end
         WAIT: begin
            if (owner == OWN_IF && if_kill) kill_nxt = 1'b1;
            if (mem_rvalid) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
            kill_nxt  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // IF requests never write, so their write data is driven as zero
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if (grant) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_if ? 1'b0 : dm_we;
            mem_addr  <= grant_if ? if_addr : dm_addr;
            mem_wdata <= grant_if ? '0 : dm_wdata;
         end else if (state == ISSUE && mem_gnt) begin
            mem_req <= 1'b0;
         end
         if (state == WAIT && mem_rvalid) begin
            if (owner == OWN_IF) if_rdata <= mem_rdata;
            else                 dm_rdata <= mem_rdata;
         end
      end
   end

   // A kill arriving during RESP suppresses the pulse combinationally
   assign if_valid  = (state == RESP) && (owner == OWN_IF) && !kill_pend && !if_kill;
   assign dm_valid  = (state == RESP) && (owner == OWN_DM);
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory that grants after a set delay.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_valid, dm_valid, mem_req, mem_we, mem_gnt, mem_rvalid;
   logic        stall_if, stall_mem;

   int checks = 0;
   int errors = 0;

   // memory model controls, written only by the main process
   int   gnt_delay = 0;
   logic no_rv     = 1'b0;
   int   stray_req = 0;

   // memory model state, written only by the memory process
   int          wcnt = 0;
   logic        rv_next = 1'b0;
   logic [31:0] rv_data = '0;
   int          gnt_cnt = 0;
   int          stray_done = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
   endfunction

   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         mem_rvalid = 1'b0;
         mem_gnt    = 1'b0;
         if (rv_next) begin
            mem_rvalid = 1'b1; mem_rdata = rv_data; rv_next = 1'b0;
         end else if (stray_req != stray_done) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; stray_done++;
         end
         if (mem_req) begin
            if (wcnt == gnt_delay) begin
               mem_gnt = 1'b1; wcnt = 0; gnt_cnt++;
               if (!no_rv) begin rv_next = 1'b1; rv_data = mem_val(mem_addr); end
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #3;
   endtask

   logic stall_if_low;

   task automatic wait_resp(input int maxc, output int lat, output logic got_if, output logic got_dm);
      lat = 0; got_if = 1'b0; got_dm = 1'b0;
      while (!got_if && !got_dm && lat < maxc) begin
         tick();
         lat++;
         if (!stall_if && !if_valid) stall_if_low = 1'b1;
         got_if = if_valid;
         got_dm = dm_valid;
      end
      check_eq("resp_seen", 32'(got_if | got_dm), 32'd1);
      check_eq("valid_excl", 32'(got_if & got_dm), 32'd0);
   endtask

   int   lat, nreq, npulse, vat, g0;
   logic gi, gd, stable;
   int   exp_dm [6] = '{1, 1, 0, 1, 1, 0};
   logic [31:0] dm_a, if_a;

   initial begin
      rst = 1'b1; if_req = 0; if_kill = 0; dm_req = 0; dm_we = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      tick(); tick();
      check_eq("rst_mem_req", 32'(mem_req), 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_valids", 32'({if_valid, dm_valid}), 0);
      rst = 1'b0;
      tick();

      // single IF read, minimum latency
      if_req = 1; if_addr = 32'h10; #1;
      check_eq("t1_stall_c0", 32'(stall_if), 1);
      stall_if_low = 0;
      wait_resp(20, lat, gi, gd);
      check_eq("t1_lat", lat, 3);
      check_eq("t1_is_if", 32'(gi), 1);
      check_eq("t1_rdata", if_rdata, 32'h0050_0093);
      check_eq("t1_stall_c3", 32'(stall_if), 0);
      check_eq("t1_stall_hold", 32'(stall_if_low), 0);
      if_req = 0;
      tick();

      // simultaneous requests: DM first, IF stalled throughout
      if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
      stall_if_low = 0;
      wait_resp(20, lat, gi, gd);
      check_eq("t2_dm_first", 32'(gd), 1);
      check_eq("t2_dm_lat", lat, 3);
      check_eq("t2_dm_rdata", dm_rdata, 32'h5A5A_0100);
      check_eq("t2_stall_if", 32'(stall_if_low), 0);
      dm_req = 0;
      wait_resp(20, lat, gi, gd);
      check_eq("t2_if_second", 32'(gi), 1);
      check_eq("t2_if_lat", lat, 4);
      check_eq("t2_if_rdata", if_rdata, 32'h5A5A_0014);

      // starvation: both requesting continuously
      dm_a = 32'h400; if_a = 32'h80;
      dm_req = 1; dm_addr = dm_a; if_req = 1; if_addr = if_a;
      for (int k = 0; k < 6; k++) begin
         wait_resp(20, lat, gi, gd);
         check_eq($sformatf("t3_order%0d", k), 32'(gd), 32'(exp_dm[k]));
         if (gd) begin
            check_eq($sformatf("t3_dm_rdata%0d", k), dm_rdata, dm_a ^ 32'h5A5A_0000);
            dm_a = dm_a + 4; dm_addr = dm_a;
         end
         if (gi) begin
            check_eq($sformatf("t3_if_rdata%0d", k), if_rdata, if_a ^ 32'h5A5A_0000);
            if_a = if_a + 4; if_addr = if_a;
         end
      end
      dm_req = 0; if_req = 0;
      tick();

      // DM write with slow grant
      gnt_delay = 3;
      dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
      nreq = 0; npulse = 0; vat = 0; stable = 1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (mem_req) begin
            nreq++;
            if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF || mem_we !== 1'b1) stable = 0;
         end
         if (dm_valid) begin npulse++; vat = c; dm_req = 0; dm_we = 0; end
      end
      check_eq("t4_issue_cycles", nreq, 4);
      check_eq("t4_stable", 32'(stable), 1);
      check_eq("t4_pulses", npulse, 1);
      check_eq("t4_valid_at", vat, 6);
      check_eq("t4_wr_ack_rdata", dm_rdata, 32'h5A5A_0200);
      gnt_delay = 0;

      // IF killed in WAIT, then a fresh fetch
      g0 = gnt_cnt;
      if_req = 1; if_addr = 32'h20;
      tick(); tick();
      if_kill = 1;
      @(posedge clk); #1 if_kill = 0; #2;
      check_eq("t5_killed_valid", 32'(if_valid), 0);
      if_addr = 32'h40;
      wait_resp(20, lat, gi, gd);
      check_eq("t5_next_if", 32'(gi), 1);
      check_eq("t5_next_lat", lat, 4);
      check_eq("t5_next_rdata", if_rdata, 32'h5A5A_0040);
      check_eq("t5_mem_grants", gnt_cnt - g0, 2);
      if_req = 0;
      tick();

      // reset while in WAIT, followed by a stray response
      no_rv = 1;
      dm_req = 1; dm_addr = 32'h300;
      tick(); tick();
      rst = 1; dm_req = 0; no_rv = 0;
      tick();
      check_eq("t6_mem_req", 32'(mem_req), 0);
      check_eq("t6_mem_we", 32'(mem_we), 0);
      check_eq("t6_mem_addr", mem_addr, 0);
      check_eq("t6_mem_wdata", mem_wdata, 0);
      check_eq("t6_if_rdata", if_rdata, 0);
      check_eq("t6_dm_rdata", dm_rdata, 0);
      rst = 0;
      stray_req = stray_req + 1;
      npulse = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (if_valid || dm_valid || mem_req) npulse++;
      end
      check_eq("t6_stray_ignored", npulse, 0);
      check_eq("t6_stray_rdata", dm_rdata, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
